// File: rtl/mv_controller.sv
// Sequencer for an iterated fixed-point matrix-vector product on a chain of MAC nodes.
// Drives matrix/vector BRAM addressing and all datapath selects; the vector ping-pongs between vbram0 and vbram1.
module mv_controller #(
    parameter int IDX_WIDTH_FOR_NODES = 3,
    parameter int NUM_NODES           = 2**IDX_WIDTH_FOR_NODES,
    parameter int DELAY_BUF           = 1,
    parameter int DELAY_MAC           = 3,
    parameter int DELAY_CIN           = 1,
    parameter int DELAY_SEL           = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           running,
    input  logic [8:0]                     width,
    input  logic [15:0]                    iteration,
    output logic                           mbram_clk,
    output logic                           vbram0_clk,
    output logic                           vbram1_clk,
    output logic                           mbram_en,
    output logic [11:0]                    mbram_addr,
    output logic                           vbram0_en,
    output logic                           vbram0_we,
    output logic [9:0]                     vbram0_addr,
    output logic                           vbram1_en,
    output logic                           vbram1_we,
    output logic [9:0]                     vbram1_addr,
    output logic [NUM_NODES-1:0]           sclrs,
    output logic [1:0]                     asel,
    output logic [NUM_NODES-1:0]           csels,
    output logic [IDX_WIDTH_FOR_NODES-1:0] ressel,
    output logic [1:0]                     dinsel,
    output logic                           finish
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = 11;
    // Offsets from the end of the matrix-row read (t0+width) to writeback start, first write and group end
    localparam logic [CW-1:0] TW_OFF = CW'((NUM_NODES-1)*DELAY_BUF + DELAY_MAC + DELAY_CIN);
    localparam logic [CW-1:0] WR_OFF = TW_OFF + CW'(DELAY_SEL);
    localparam logic [CW-1:0] TAIL   = WR_OFF + CW'(NUM_NODES-1);

    state_t                         state_q, state_d;
    logic [8:0]                     width_q, width_d;
    logic [15:0]                    iter_q, iter_d;
    logic [15:0]                    pass_q, pass_d;
    logic [8:0]                     group_q, group_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [11:0]                    base_q, base_d;
    logic [IDX_WIDTH_FOR_NODES-1:0] ressel_q, ressel_d;

    logic [CW-1:0] w_ext, tw, wr_start, c_last, rs_k, wr_k;
    logic [9:0]    num_groups;
    logic [15:0]   wr_idx;
    logic          active, src1, rd_act, wr_act;

    assign mbram_clk  = clk;
    assign vbram0_clk = clk;
    assign vbram1_clk = clk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            width_q  <= '0;
            iter_q   <= '0;
            pass_q   <= '0;
            group_q  <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            ressel_q <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            iter_q   <= iter_d;
            pass_q   <= pass_d;
            group_q  <= group_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            ressel_q <= ressel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        iter_d      = iter_q;
        pass_d      = pass_q;
        group_d     = group_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        ressel_d    = ressel_q;
        mbram_en    = 1'b0;
        mbram_addr  = '0;
        vbram0_en   = 1'b0;
        vbram0_we   = 1'b0;
        vbram0_addr = '0;
        vbram1_en   = 1'b0;
        vbram1_we   = 1'b0;
        vbram1_addr = '0;
        sclrs       = '0;
        asel        = 2'd0;
        csels       = '0;
        dinsel      = 2'd0;
        finish      = 1'b0;

        w_ext      = CW'(width_q);
        tw         = w_ext + TW_OFF;
        wr_start   = w_ext + WR_OFF;
        c_last     = w_ext + TAIL;
        num_groups = (10'(width_q) + 10'(NUM_NODES-1)) >> IDX_WIDTH_FOR_NODES;
        rs_k       = cnt_q - tw;
        wr_k       = cnt_q - wr_start;
        wr_idx     = 16'(group_q) * 16'(NUM_NODES) + 16'(wr_k);

        // Outputs are gated by running so an abort suppresses writes in the very cycle it is seen
        active = (state_q == RUN) && running;
        src1   = pass_q[0];
        rd_act = active && (cnt_q < w_ext);
        wr_act = active && (cnt_q >= wr_start) && (wr_k < CW'(NUM_NODES))
                 && (wr_idx < 16'(width_q));

        case (state_q)
            IDLE: begin
                ressel_d = '0;
                if (running) begin
                    width_d = width;
                    iter_d  = iteration;
                    pass_d  = '0;
                    group_d = '0;
                    cnt_d   = '0;
                    base_d  = '0;
                    state_d = (width == 9'd0 || iteration == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!running) begin
                    state_d  = IDLE;
                    ressel_d = '0;
                end else if (cnt_q == c_last) begin
                    cnt_d = '0;
                    if (10'(group_q) == num_groups - 10'd1) begin
                        group_d = '0;
                        base_d  = '0;
                        if (pass_q == iter_q - 16'd1) begin
                            state_d = DONE;
                        end else begin
                            pass_d = pass_q + 16'd1;
                        end
                    end else begin
                        group_d = group_q + 9'd1;
                        base_d  = base_q + 12'(width_q);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                finish = 1'b1;
                if (!running) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_act) begin
            mbram_en   = 1'b1;
            mbram_addr = base_q + 12'(cnt_q);
            if (src1) begin
                vbram1_en   = 1'b1;
                vbram1_addr = cnt_q[9:0];
            end else begin
                vbram0_en   = 1'b1;
                vbram0_addr = cnt_q[9:0];
            end
        end

        if (active && (cnt_q >= CW'(1)) && (cnt_q <= w_ext)) begin
            asel = src1 ? 2'd2 : 2'd1;
        end

        for (int i = 0; i < NUM_NODES; i++) begin
            sclrs[i] = active && (cnt_q == CW'(1 + i*DELAY_BUF));
            csels[i] = active && (cnt_q == w_ext + CW'(i*DELAY_BUF + DELAY_MAC));
        end

        // ressel steps through the nodes during writeback and otherwise holds its last value
        if (active && (cnt_q >= tw) && (rs_k < CW'(NUM_NODES))) begin
            ressel_d = rs_k[IDX_WIDTH_FOR_NODES-1:0];
        end
        ressel = ressel_d;

        if (wr_act) begin
            if (src1) begin
                vbram0_en   = 1'b1;
                vbram0_we   = 1'b1;
                vbram0_addr = wr_idx[9:0];
                dinsel      = 2'd1;
            end else begin
                vbram1_en   = 1'b1;
                vbram1_we   = 1'b1;
                vbram1_addr = wr_idx[9:0];
                dinsel      = 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_mv_controller.sv
// Self-checking bench for mv_controller: per-cycle comparison against a time-indexed
// reference model, a table of complete jobs, hand-written corner sequences and random jobs.
module tb_mv_controller;

    localparam int IDX = 3;
    localparam int N   = 1 << IDX;
    localparam int DB  = 1;
    localparam int DM  = 3;
    localparam int DC  = 1;
    localparam int DS  = 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          running;
    logic [8:0]    width;
    logic [15:0]   iteration;
    logic          mbram_clk, vbram0_clk, vbram1_clk;
    logic          mbram_en;
    logic [11:0]   mbram_addr;
    logic          vbram0_en, vbram0_we, vbram1_en, vbram1_we;
    logic [9:0]    vbram0_addr, vbram1_addr;
    logic [N-1:0]  sclrs, csels;
    logic [1:0]    asel, dinsel;
    logic [IDX-1:0] ressel;
    logic          finish;

    mv_controller dut (
        .clk         (clk),
        .rstn        (rstn),
        .running     (running),
        .width       (width),
        .iteration   (iteration),
        .mbram_clk   (mbram_clk),
        .vbram0_clk  (vbram0_clk),
        .vbram1_clk  (vbram1_clk),
        .mbram_en    (mbram_en),
        .mbram_addr  (mbram_addr),
        .vbram0_en   (vbram0_en),
        .vbram0_we   (vbram0_we),
        .vbram0_addr (vbram0_addr),
        .vbram1_en   (vbram1_en),
        .vbram1_we   (vbram1_we),
        .vbram1_addr (vbram1_addr),
        .sclrs       (sclrs),
        .asel        (asel),
        .csels       (csels),
        .ressel      (ressel),
        .dinsel      (dinsel),
        .finish      (finish)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           mbram_en;
        logic [11:0]    mbram_addr;
        logic           v0_en;
        logic           v0_we;
        logic [9:0]     v0_addr;
        logic           v1_en;
        logic           v1_we;
        logic [9:0]     v1_addr;
        logic [N-1:0]   sclrs;
        logic [1:0]     asel;
        logic [N-1:0]   csels;
        logic [IDX-1:0] ressel;
        logic [1:0]     dinsel;
        logic           finish;
    } outs_t;

    typedef struct {
        int w;
        int it;
        int exp_finish;
        int exp_wr0;
        int exp_wr1;
    } vec_t;

    typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;

    int      checks = 0;
    int      errors = 0;
    mphase_t m_phase;
    int      m_w, m_it, m_rel, m_last;
    outs_t   want_q;
    logic    last_finish;
    int      wr0, wr1;
    int      sclr_first [N];
    int      csel_first [N];
    int      first_wr_rel, addr7_wr_rel;

    function automatic int grp_len(input int w);
        return w + (N-1)*DB + DM + DC + (N-1) + DS + 1;
    endfunction

    function automatic int job_len(input int w, input int it);
        return ((w + N - 1) / N) * grp_len(w) * it;
    endfunction

    // Expected outputs from the job start time alone: pass, group and cycle come from division
    function automatic outs_t model_outputs();
        outs_t e;
        int L, G, p, g, c, tw, k;
        bit s1;
        e = '0;
        if (m_phase == M_DONE) begin
            e.finish = 1'b1;
            e.ressel = IDX'(m_last);
        end else if (m_phase == M_RUN && running) begin
            L  = grp_len(m_w);
            G  = (m_w + N - 1) / N;
            p  = m_rel / (G * L);
            g  = (m_rel / L) % G;
            c  = m_rel % L;
            tw = m_w + (N-1)*DB + DM + DC;
            s1 = (p % 2) == 1;
            if (c < m_w) begin
                e.mbram_en   = 1'b1;
                e.mbram_addr = 12'((g * m_w + c) % 4096);
                if (s1) begin e.v1_en = 1'b1; e.v1_addr = 10'(c); end
                else    begin e.v0_en = 1'b1; e.v0_addr = 10'(c); end
            end
            if (c >= 1 && c <= m_w) e.asel = s1 ? 2'd2 : 2'd1;
            for (int i = 0; i < N; i++) begin
                if (c == 1 + i*DB)         e.sclrs[i] = 1'b1;
                if (c == m_w + i*DB + DM)  e.csels[i] = 1'b1;
            end
            e.ressel = IDX'(m_last);
            if (c >= tw && c < tw + N) e.ressel = IDX'(c - tw);
            k = c - tw - DS;
            if (k >= 0 && k < N && g*N + k < m_w) begin
                e.dinsel = s1 ? 2'd1 : 2'd2;
                if (s1) begin e.v0_en = 1'b1; e.v0_we = 1'b1; e.v0_addr = 10'(g*N + k); end
                else    begin e.v1_en = 1'b1; e.v1_we = 1'b1; e.v1_addr = 10'(g*N + k); end
            end
        end
        return e;
    endfunction

    function automatic outs_t dut_outputs();
        return {mbram_en, mbram_addr, vbram0_en, vbram0_we, vbram0_addr,
                vbram1_en, vbram1_we, vbram1_addr, sclrs, asel, csels,
                ressel, dinsel, finish};
    endfunction

    task automatic checkOutput();
        outs_t got, want;
        want   = model_outputs();
        got    = dut_outputs();
        want_q = want;
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL outputs phase=%0d rel=%0d got=%h want=%h", m_phase, m_rel, got, want);
        end
        last_finish = finish;
        if (vbram0_en && vbram0_we) wr0++;
        if (vbram1_en && vbram1_we) wr1++;
        if (m_phase == M_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (sclrs[i] && sclr_first[i] < 0) sclr_first[i] = m_rel;
                if (csels[i] && csel_first[i] < 0) csel_first[i] = m_rel;
            end
            if (vbram1_we && first_wr_rel < 0) first_wr_rel = m_rel;
            if (vbram1_we && vbram1_addr == 10'd7 && addr7_wr_rel < 0) addr7_wr_rel = m_rel;
        end
    endtask

    task automatic modelAdvance();
        case (m_phase)
            M_IDLE: if (running) begin
                m_w    = int'(width);
                m_it   = int'(iteration);
                m_rel  = 0;
                m_last = 0;
                m_phase = (m_w == 0 || m_it == 0) ? M_DONE : M_RUN;
            end
            M_RUN: if (!running) begin
                m_phase = M_IDLE;
                m_last  = 0;
            end else begin
                m_last = int'(want_q.ressel);
                m_rel++;
                if (m_rel == job_len(m_w, m_it)) m_phase = M_DONE;
            end
            default: if (!running) begin
                m_phase = M_IDLE;
                m_last  = 0;
            end
        endcase
    endtask

    // One clock cycle: drive just after the edge, sample at the falling edge
    task automatic applyStimulus(input logic run_val);
        running = run_val;
        @(negedge clk);
        checkOutput();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic expectInt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic runJob(input int w, input int it, input int budget, output int finish_at);
        finish_at    = -1;
        wr0          = 0;
        wr1          = 0;
        first_wr_rel = -1;
        addr7_wr_rel = -1;
        for (int i = 0; i < N; i++) begin
            sclr_first[i] = -1;
            csel_first[i] = -1;
        end
        width     = 9'(w);
        iteration = 16'(it);
        applyStimulus(1'b1);
        width     = 9'($urandom);
        iteration = 16'($urandom);
        for (int n = 0; n < budget; n++) begin
            applyStimulus(1'b1);
            if (last_finish) begin
                finish_at = n;
                break;
            end
        end
        checks++;
        if (finish_at < 0) begin
            errors++;
            $display("[TB] FAIL finish_timeout got=none want=finish within %0d cycles", budget);
        end
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
    endtask

    vec_t vecs [8];
    int   fin;

    initial begin
        vecs[0] = '{17, 1, 111,   0,  17};
        vecs[1] = '{17, 3, 333,  17,  34};
        vecs[2] = '{24, 1, 132,   0,  24};
        vecs[3] = '{0,  4,   0,   0,   0};
        vecs[4] = '{9,  0,   0,   0,   0};
        vecs[5] = '{8,  2,  56,   8,   8};
        vecs[6] = '{1,  1,  21,   0,   1};
        vecs[7] = '{300, 1, 12160, 0, 300};

        rstn      = 1'b1;
        running   = 1'b0;
        width     = '0;
        iteration = '0;
        m_phase   = M_IDLE;
        m_last    = 0;
        m_rel     = 0;
        #2 rstn = 1'b0;
        #1;
        expectInt("reset_outputs", int'(dut_outputs() != '0), 0);
        #20;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0);

        for (int v = 0; v < 8; v++) begin
            runJob(vecs[v].w, vecs[v].it, job_len(vecs[v].w, vecs[v].it) + 10, fin);
            expectInt($sformatf("finish_cycle_%0d", v), fin, vecs[v].exp_finish);
            expectInt($sformatf("writes_vbram0_%0d", v), wr0, vecs[v].exp_wr0);
            expectInt($sformatf("writes_vbram1_%0d", v), wr1, vecs[v].exp_wr1);
        end

        runJob(17, 1, 200, fin);
        for (int i = 0; i < N; i++) begin
            expectInt($sformatf("sclrs_time_%0d", i), sclr_first[i], 1 + i*DB);
            expectInt($sformatf("csels_time_%0d", i), csel_first[i], 17 + i*DB + DM);
        end
        expectInt("first_write_time", first_wr_rel, 17 + (N-1)*DB + DM + DC + DS);
        expectInt("addr7_write_time", addr7_wr_rel, 17 + (N-1)*DB + DM + DC + DS + 7);

        wr0 = 0;
        wr1 = 0;
        width     = 9'd24;
        iteration = 16'd1;
        applyStimulus(1'b1);
        for (int n = 0; n < 50; n++) applyStimulus(1'b1);
        expectInt("abort_writes_before", wr1, 8);
        wr0 = 0;
        wr1 = 0;
        for (int n = 0; n < 30; n++) applyStimulus(1'b0);
        expectInt("abort_writes_after", wr0 + wr1, 0);
        expectInt("abort_finish", int'(last_finish), 0);

        width     = 9'd17;
        iteration = 16'd3;
        applyStimulus(1'b1);
        for (int n = 0; n < 60; n++) applyStimulus(1'b1);
        rstn = 1'b0;
        #1;
        expectInt("midrun_reset_outputs", int'(dut_outputs() != '0), 0);
        m_phase = M_IDLE;
        m_last  = 0;
        running = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0);
        runJob(17, 1, 200, fin);
        expectInt("post_reset_finish", fin, 111);

        for (int j = 0; j < 12; j++) begin
            int  w, it, tot, ab;
            bit  stop;
            w    = $urandom_range(1, 40);
            it   = $urandom_range(1, 3);
            tot  = job_len(w, it);
            ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tot - 1) : -1;
            stop = 1'b0;
            width     = 9'(w);
            iteration = 16'(it);
            applyStimulus(1'b1);
            width     = 9'($urandom);
            iteration = 16'($urandom);
            for (int n = 0; n < tot + 5 && !stop; n++) begin
                if (n == ab) begin
                    applyStimulus(1'b0);
                    stop = 1'b1;
                end else begin
                    applyStimulus(1'b1);
                    if (last_finish) stop = 1'b1;
                end
            end
            if (ab < 0) expectInt($sformatf("random_finish_%0d", j), int'(last_finish), 1);
            applyStimulus(1'b0);
            applyStimulus(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mv_controller.md
Name: mv_controller

Overview:
- Sequencer for a fixed-point matrix-vector engine of NUM_NODES chained MAC nodes.
- Computes x(k+1) = M * x(k), width x width, repeated `iteration` times.
- The vector ping-pongs between vbram0 and vbram1.
- Drives BRAM addresses/enables and all datapath selects (clear, a-select, capture, result mux, din routing); holds no data itself.

Parameters:
- IDX_WIDTH_FOR_NODES, 3, bits of node index.
- NUM_NODES, 2**IDX_WIDTH_FOR_NODES, number of MAC nodes (N).
- DELAY_BUF, 1, cycles per node hop of the a-operand chain.
- DELAY_MAC, 3, MAC pipeline latency.
- DELAY_CIN, 1, cycles from csels pulse to node result valid.
- DELAY_SEL, 1, cycles from ressel change to BRAM din valid.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- running  in  1  high = start/continue; low = abort/acknowledge.
- width  in  9  vector length / matrix dimension.
- iteration  in  16  number of multiply passes.
- mbram_clk, vbram0_clk, vbram1_clk  out  1 each  = clk.
- mbram_en  out  1  matrix read enable.
- mbram_addr  out  12  matrix address.
- vbram0_en/we, vbram1_en/we  out  1 each  vector BRAM enables/write enables.
- vbram0_addr, vbram1_addr  out  10 each  vector addresses.
- sclrs  out  NUM_NODES  per-node accumulator clear (load instead of accumulate).
- asel  out  2  first-node a source: 0 zero, 1 vbram0 dout, 2 vbram1 dout.
- csels  out  NUM_NODES  per-node result capture pulse.
- ressel  out  IDX_WIDTH_FOR_NODES  node result routed to din.
- dinsel  out  2  din routing: 0 none, 1 vbram0, 2 vbram1.
- finish  out  1  job complete.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: async on rstn low. State IDLE, all counters 0, every output 0 except the *_clk passthroughs.
- IDLE -> RUN: running high. Latch width and iteration that cycle.
- If latched width==0 or iteration==0: go to DONE instead.
- Pass p (0-based): src = vbram0 if p even else vbram1; dst = the other BRAM.
- Groups per pass: G = ceil(width/N). Groups run strictly sequentially, no overlap.
- Group g timing, relative to t0 (first cycle of the group), for c = 0..width-1:
  - Cycle t0+c: mbram_en=1, mbram_addr=(g*width+c) mod 4096. src en=1, we=0, addr=c.
  - asel = src code for cycles t0+1 .. t0+width; 0 otherwise.
- sclrs[i]: high exactly at t0+1+i*DELAY_BUF.
- csels[i]: high exactly at t0+width+i*DELAY_BUF+DELAY_MAC.
- Writeback start: Tw = t0+width+(N-1)*DELAY_BUF+DELAY_MAC+DELAY_CIN.
- For k = 0..N-1:
  - ressel = k at Tw+k; ressel holds its last value otherwise.
  - At Tw+k+DELAY_SEL, if g*N+k < width: dst en=1, we=1, addr=g*N+k, dinsel = dst code. Otherwise dinsel=0, no write.
- Group length = Tw+N-1+DELAY_SEL - t0 + 1. With defaults this is width+20. Next group or pass begins the following cycle.
- Src reads and dst writes never target the same BRAM in one cycle.
- After the last write of the last group of the last pass: DONE. finish=1 from the next cycle, held while running is high.
- DONE -> IDLE when running low; finish drops the same edge.
- running low in RUN: abort to IDLE next cycle. All enables/selects go 0 and no further writes occur.
- width and iteration are ignored outside the IDLE->RUN latch.
- vbram addresses are truncated to 10 bits. mbram_addr wraps mod 4096.

Test Plan:
- Reset mid-RUN (rstn low at any cycle) -> all outputs 0 immediately. State IDLE; a new run starts cleanly after rstn high.
- width=17, iteration=1, defaults -> 3 groups of 37 cycles.
  - mbram_addr sequences 0..16, 17..33, 34..50.
  - vbram0 reads addr 0..16 per group.
  - vbram1 writes addr 0..16: groups 0 and 1 write 8 each, group 2 writes only addr 16, with dinsel=2.
  - finish at cycle 111 after start.
- width=17, iteration=3 -> passes alternate src vbram0, vbram1, vbram0; final writes land in vbram1. finish at cycle 333.
- Per-node timing, group 0 -> sclrs[i] at t0+1+i and csels[i] at t0+20+i, i=0..7. ressel 0..7 over t0+28..t0+35; writes at t0+29..t0+36.
- width=0 or iteration=0 -> no BRAM enables; finish high the cycle after DONE entry.
- width=24 after a completed run -> finish clears when running drops.
  - 3 full groups of 44 cycles; vbram1 addr 0..23 written.
  - Dropping running at cycle 50 aborts with no further writes.
